// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: two requester ports plus the shared MIG app channel.
// master is the arbiter's view; slave is the requesters/controller side.
interface mem_bus_arbiter_if;
    logic         p0_en, p0_we, p0_ack;
    logic [27:0]  p0_addr;
    logic [127:0] p0_wdata, p0_rdata;
    logic [15:0]  p0_wmask;
    logic         p1_en, p1_we, p1_ack;
    logic [27:0]  p1_addr;
    logic [127:0] p1_wdata, p1_rdata;
    logic [15:0]  p1_wmask;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end, app_wdf_wren, app_wdf_rdy;
    logic [15:0]  app_wdf_mask;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid, app_rd_data_end;

    modport master (
        input  p0_en, p0_we, p0_addr, p0_wdata, p0_wmask,
        input  p1_en, p1_we, p1_addr, p1_wdata, p1_wmask,
        output p0_ack, p0_rdata, p1_ack, p1_rdata,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        output p0_en, p0_we, p0_addr, p0_wdata, p0_wmask,
        output p1_en, p1_we, p1_addr, p1_wdata, p1_wmask,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises two requesters onto one MIG app interface with
// exclusive or round-robin ownership and a bounded wait for read data.
module mem_bus_arbiter #(
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        bus_mode,
    mem_bus_arbiter_if.master bus,
    output logic              busy,
    output logic              err_timeout
);
    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t        state;
    logic          port, last_grant;
    logic [CW-1:0] cnt;
    logic          req0, req1, pick, pick_we, rd, cmd_ok, wdf_ok, unused_rd_end;

    // app_en / app_wdf_wren stay high until accepted, so they double as the not-done flags
    always_comb begin
        req0    = bus.p0_en && bus_mode != 2'b01;
        req1    = bus.p1_en && bus_mode != 2'b00;
        pick    = req0 && req1 ? !last_grant : req1;
        pick_we = pick ? bus.p1_we : bus.p0_we;
        rd      = bus.app_cmd[0];
        cmd_ok  = !bus.app_en || bus.app_rdy;
        wdf_ok  = !bus.app_wdf_wren || bus.app_wdf_rdy;
    end

    assign busy          = state != IDLE;
    assign unused_rd_end = bus.app_rd_data_end;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            port             <= 1'b0;
            last_grant       <= 1'b1;
            cnt              <= '0;
            err_timeout      <= 1'b0;
            bus.app_addr     <= '0;
            bus.app_cmd      <= '0;
            bus.app_en       <= 1'b0;
            bus.app_wdf_data <= '0;
            bus.app_wdf_mask <= '0;
            bus.app_wdf_end  <= 1'b0;
            bus.app_wdf_wren <= 1'b0;
            bus.p0_ack       <= 1'b0;
            bus.p1_ack       <= 1'b0;
            bus.p0_rdata     <= '0;
            bus.p1_rdata     <= '0;
        end else begin
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            case (state)
                IDLE: if (req0 || req1) begin
                    state            <= ISSUE;
                    port             <= pick;
                    last_grant       <= pick;
                    bus.app_en       <= 1'b1;
                    bus.app_addr     <= pick ? bus.p1_addr : bus.p0_addr;
                    bus.app_cmd      <= {2'b00, !pick_we};
                    bus.app_wdf_data <= pick ? bus.p1_wdata : bus.p0_wdata;
                    bus.app_wdf_mask <= pick ? bus.p1_wmask : bus.p0_wmask;
                    bus.app_wdf_wren <= pick_we;
                    bus.app_wdf_end  <= pick_we;
                end
                ISSUE: begin
                    if (bus.app_rdy) bus.app_en <= 1'b0;
                    if (bus.app_wdf_rdy) bus.app_wdf_wren <= 1'b0;
                    if (cmd_ok && wdf_ok) begin
                        if (rd) begin
                            state <= RD_WAIT;
                            cnt   <= '0;
                        end else begin
                            state                    <= IDLE;
                            bus.app_wdf_end          <= 1'b0;
                            {bus.p1_ack, bus.p0_ack} <= port ? 2'b10 : 2'b01;
                        end
                    end
                end
                RD_WAIT: if (bus.app_rd_data_valid || cnt == CW'(RD_TIMEOUT - 1)) begin
                    state                    <= IDLE;
                    {bus.p1_ack, bus.p0_ack} <= port ? 2'b10 : 2'b01;
                    if (port) bus.p1_rdata <= bus.app_rd_data_valid ? bus.app_rd_data : '0;
                    else bus.p0_rdata <= bus.app_rd_data_valid ? bus.app_rd_data : '0;
                    if (!bus.app_rd_data_valid) err_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios against a transaction-level model
// compared every cycle, plus literal checks on latencies and data.
module tb_mem_bus_arbiter;
    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] bus_mode = 2'b00;
    logic       busy, err_timeout;
    int         n_cmp = 0, n_bad = 0;
    int         rd_lat = 5;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(.RD_TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus_mode   (bus_mode),
        .bus        (bus),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int p, input bit we, input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        if (p == 0) begin
            bus.p0_en = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_wmask = m;
        end else begin
            bus.p1_en = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_wmask = m;
        end
    endtask

    // Reference model: one in-flight transaction record, advanced once per clock
    typedef struct {
        int           port;
        bit           we;
        logic [27:0]  addr;
        logic [127:0] wd;
        logic [15:0]  wm;
    } txn_t;

    txn_t         cur;
    bit           m_busy, m_wait_ph, m_cmd, m_wdf, e_err, e_rd;
    bit           e_ack [2];
    logic [127:0] e_rdata [2];
    int           m_last, m_wait;

    initial begin
        bit q0, q1;
        m_busy = 0; m_last = 1; e_err = 0; e_rd = 0; m_cmd = 0; m_wdf = 0; m_wait_ph = 0; m_wait = 0;
        e_ack = '{0, 0};
        e_rdata = '{default: '0};
        cur.port = 0; cur.we = 0;
        forever begin
            @(posedge clk or negedge resetn);
            e_ack = '{0, 0};
            if (!resetn) begin
                m_busy = 0; m_last = 1; e_err = 0; e_rd = 0; m_wait_ph = 0;
                e_rdata = '{default: '0};
            end else if (!m_busy) begin
                q0 = bus.p0_en && bus_mode != 2'd1;
                q1 = bus.p1_en && bus_mode != 2'd0;
                if (q0 || q1) begin
                    cur.port  = (q0 && q1) ? 1 - m_last : (q1 ? 1 : 0);
                    m_last    = cur.port;
                    cur.we    = cur.port == 1 ? bus.p1_we : bus.p0_we;
                    cur.addr  = cur.port == 1 ? bus.p1_addr : bus.p0_addr;
                    cur.wd    = cur.port == 1 ? bus.p1_wdata : bus.p0_wdata;
                    cur.wm    = cur.port == 1 ? bus.p1_wmask : bus.p0_wmask;
                    m_busy    = 1; m_wait_ph = 0; m_cmd = 0; m_wdf = !cur.we;
                end
            end else if (!m_wait_ph) begin
                m_cmd = m_cmd | bus.app_rdy;
                m_wdf = m_wdf | bus.app_wdf_rdy;
                if (cur.we && m_cmd && m_wdf) begin
                    e_ack[cur.port] = 1; m_busy = 0; e_rd = 0;
                end else if (!cur.we && m_cmd) begin
                    m_wait_ph = 1; m_wait = 0;
                end
            end else begin
                m_wait++;
                if (bus.app_rd_data_valid) begin
                    e_ack[cur.port] = 1; e_rdata[cur.port] = bus.app_rd_data; m_busy = 0; e_rd = 1;
                end else if (m_wait == TO) begin
                    e_ack[cur.port] = 1; e_rdata[cur.port] = '0; e_err = 1; m_busy = 0; e_rd = 1;
                end
            end
        end
    end

    initial begin
        bit e_en, e_wr;
        forever begin
            @(negedge clk);
            e_en = m_busy && !m_wait_ph && !m_cmd;
            e_wr = m_busy && !m_wait_ph && cur.we && !m_wdf;
            chk("busy", busy, m_busy);
            chk("err_timeout", err_timeout, e_err);
            chk("p0_ack", bus.p0_ack, e_ack[0]);
            chk("p1_ack", bus.p1_ack, e_ack[1]);
            if (e_ack[0] && e_rd) chk("p0_rdata", bus.p0_rdata, e_rdata[0]);
            if (e_ack[1] && e_rd) chk("p1_rdata", bus.p1_rdata, e_rdata[1]);
            chk("app_en", bus.app_en, e_en);
            chk("app_wdf_wren", bus.app_wdf_wren, e_wr);
            if (e_en) begin
                chk("app_addr", bus.app_addr, cur.addr);
                chk("app_cmd", bus.app_cmd, {2'b00, !cur.we});
            end
            if (e_wr) begin
                chk("app_wdf_data", bus.app_wdf_data, cur.wd);
                chk("app_wdf_mask", bus.app_wdf_mask, cur.wm);
                chk("app_wdf_end", bus.app_wdf_end, 1'b1);
            end
        end
    end

    // MIG read responder: data = 0x1234 + addr, rd_lat cycles after the command is accepted
    initial begin
        int cd;
        logic [27:0] ra;
        cd = 0; ra = '0;
        bus.app_rd_data_valid = 1'b0; bus.app_rd_data_end = 1'b0; bus.app_rd_data = '0;
        forever begin
            @(negedge clk);
            if (bus.app_en && bus.app_rdy && bus.app_cmd[0] && rd_lat > 0) begin
                cd = rd_lat;
                ra = bus.app_addr;
            end
            @(posedge clk);
            #1;
            bus.app_rd_data_valid = 1'b0;
            bus.app_rd_data_end   = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.app_rd_data_valid = 1'b1;
                    bus.app_rd_data_end   = 1'b1;
                    bus.app_rd_data       = 128'h1234 + 128'(ra);
                end
            end
        end
    end

    initial begin
        int k, at, n_en, n_wr;
        int ports [4];
        logic [127:0] dat [4];
        logic [127:0] t2_exp [4];
        bus.p0_en = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wmask = '0;
        bus.p1_en = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wmask = '0;
        bus.app_rdy = 0; bus.app_wdf_rdy = 0;
        step(2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_app_en", bus.app_en, 1'b0);
        chk("rst_app_wren", bus.app_wdf_wren, 1'b0);
        chk("rst_app_addr", bus.app_addr, 28'h0);
        chk("rst_app_cmd", bus.app_cmd, 3'h0);
        chk("rst_p0_rdata", bus.p0_rdata, 128'h0);
        chk("rst_p1_ack", bus.p1_ack, 1'b0);
        resetn = 1'b1;
        step();

        // Mode 00 write from p0, p1 must be ignored
        bus.app_rdy = 1; bus.app_wdf_rdy = 1; bus_mode = 2'b00;
        req(1, 0, 28'h77, '0, '0);
        req(0, 1, 28'h10, 128'hAA << 8, 16'hFFFD);
        step();
        chk("t1_app_en", bus.app_en, 1'b1);
        chk("t1_app_wren", bus.app_wdf_wren, 1'b1);
        chk("t1_app_cmd", bus.app_cmd, 3'h0);
        chk("t1_app_addr", bus.app_addr, 28'h10);
        chk("t1_wdata", bus.app_wdf_data, 128'hAA00);
        chk("t1_wmask", bus.app_wdf_mask, 16'hFFFD);
        step();
        chk("t1_p0_ack", bus.p0_ack, 1'b1);
        chk("t1_app_en_off", bus.app_en, 1'b0);
        bus.p0_en = 0;
        k = 0;
        repeat (6) begin
            step();
            k += bus.p1_ack;
        end
        chk("t1_p1_ignored", k, 0);
        chk("t1_idle", busy, 1'b0);
        bus.p1_en = 0;

        // Round-robin reads, both ports requesting continuously
        resetn = 1'b0; step(); resetn = 1'b1; step();
        bus_mode = 2'b10; rd_lat = 5;
        req(0, 0, 28'h100, '0, '0);
        req(1, 0, 28'h200, '0, '0);
        k = 0;
        for (int i = 0; i < 200 && k < 4; i++) begin
            step();
            if (bus.p0_ack) begin
                ports[k] = 0; dat[k] = bus.p0_rdata; k++; bus.p0_addr = bus.p0_addr + 28'd1;
            end else if (bus.p1_ack) begin
                ports[k] = 1; dat[k] = bus.p1_rdata; k++; bus.p1_addr = bus.p1_addr + 28'd1;
            end
            if (k == 4) begin
                bus.p0_en = 0; bus.p1_en = 0;
            end
        end
        chk("t2_ack_count", k, 4);
        t2_exp = '{128'h1334, 128'h1434, 128'h1335, 128'h1435};
        for (int i = 0; i < k; i++) begin
            chk("t2_port", ports[i], i % 2);
            chk("t2_rdata", dat[i], t2_exp[i]);
        end
        bus.p0_en = 0; bus.p1_en = 0;
        step();

        // Write with the data channel stalled for three cycles
        bus_mode = 2'b00; bus.app_rdy = 1; bus.app_wdf_rdy = 0;
        req(0, 1, 28'h40, 128'h5555, 16'h0000);
        at = 0; n_en = 0; n_wr = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) bus.app_wdf_rdy = 1;
            n_en += bus.app_en;
            n_wr += bus.app_wdf_wren;
            if (bus.p0_ack) begin
                at = i; bus.p0_en = 0;
            end
        end
        chk("t3_ack_cycle", at, 5);
        chk("t3_en_cycles", n_en, 1);
        chk("t3_wren_cycles", n_wr, 4);

        // Read timeout
        rd_lat = 0;
        req(0, 0, 28'h50, '0, '0);
        at = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if (bus.p0_ack) begin
                at = i; bus.p0_en = 0;
                chk("t4_rdata", bus.p0_rdata, 128'h0);
            end
        end
        chk("t4_ack_cycle", at, 17);
        chk("t4_err", err_timeout, 1'b1);

        // Mode switch while p0 read is waiting for data
        rd_lat = 5;
        req(1, 0, 28'h400, '0, '0);
        req(0, 0, 28'h300, '0, '0);
        at = 0; k = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 3) bus_mode = 2'b01;
            if (bus.p0_ack) begin
                at = i; dat[0] = bus.p0_rdata; bus.p0_en = 0;
            end
            if (bus.p1_ack) begin
                k = i; dat[1] = bus.p1_rdata; bus.p1_en = 0;
            end
        end
        chk("t5_p0_ack_cycle", at, 7);
        chk("t5_p0_rdata", dat[0], 128'h1534);
        chk("t5_p1_ack_cycle", k, 14);
        chk("t5_p1_rdata", dat[1], 128'h1634);
        chk("t5_err_sticky", err_timeout, 1'b1);

        // Reset during read wait; late data must be ignored
        rd_lat = 8;
        req(1, 0, 28'h500, '0, '0);
        k = 0;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 3) begin
                resetn = 1'b0; bus.p1_en = 0;
            end
            if (i == 5) resetn = 1'b1;
            k += bus.p0_ack + bus.p1_ack;
        end
        chk("t6_no_ack", k, 0);
        chk("t6_idle", busy, 1'b0);
        chk("t6_err_cleared", err_timeout, 1'b0);
        chk("t6_rdata", bus.p1_rdata, 128'h0);
        req(1, 1, 28'h20, 128'hBEEF, 16'h0000);
        at = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus.p1_ack) begin
                at = i; bus.p1_en = 0;
            end
        end
        chk("t6_next_ack_cycle", at, 2);

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
